fifo_goal_monitor: RTL

- Downstream observer of the fifo block in the full/empty goal environment.
- Snoops the fifo's inputs (push, pop, datain) and outputs (full, empty, count, dataout) on the same clock.
- Keeps a shadow queue model and flags protocol and data errors.
- Runs a goal FSM that alternates "reach full" / "reach empty" and emits a registered reward pulse plus episode bookkeeping to the RL agent.

---
 rtl/fifo_goal_monitor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_goal_monitor.sv
// Observer for the full/empty goal fifo: mirrors the queue in a shadow
// model, flags protocol/data errors and drives the RL goal/episode outputs.
module fifo_goal_monitor #(
  parameter int width     = 8,
  parameter int depth     = 4,
  parameter int log2depth = 2,
  parameter int max_steps = 64,
  parameter int step_w    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [width-1:0]     datain,
  input  logic                 full,
  input  logic                 empty,
  input  logic [log2depth:0]   count,
  input  logic [width-1:0]     dataout,
  output logic                 reward,
  output logic                 goal_state,
  output logic [step_w-1:0]    goal_cnt,
  output logic [step_w-1:0]    step_cnt,
  output logic                 episode_done,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_data,
  output logic                 err_count
);

  typedef enum logic {
    SEEK_FULL  = 1'b0,
    SEEK_EMPTY = 1'b1
  } goal_t;

  localparam logic [log2depth:0] DEPTH =
    (log2depth+1)'(depth);
  localparam logic [log2depth:0] OCC_ONE =
    (log2depth+1)'(1);
  localparam logic [step_w-1:0] LAST =
    step_w'(max_steps - 1);
  localparam logic [step_w-1:0] STEP_ONE =
    step_w'(1);
  localparam logic [log2depth-1:0] PTR_ONE =
    log2depth'(1);

  goal_t                state;
  logic [width-1:0]     mem [depth];
  logic [log2depth-1:0] wr_ptr;
  logic [log2depth-1:0] rd_ptr;
  logic [log2depth:0]   occ;
  logic [log2depth:0]   occ_nxt;

  logic s_full;
  logic s_empty;
  logic ovf;
  logic unf;
  logic wr_en;
  logic rd_en;
  logic head_bad;
  logic cnt_bad;
  logic goal_hit;
  logic last;

  always_comb begin
    s_full   = (occ == DEPTH);
    s_empty  = (occ == '0);
    ovf      = push & ~pop & s_full;
    unf      = pop & s_empty;
    wr_en    = push & ~ovf & ~unf;
    rd_en    = pop & ~unf;
    occ_nxt  = occ;
    unique case ({wr_en, rd_en})
      2'b10:   occ_nxt = occ + OCC_ONE;
      2'b01:   occ_nxt = occ - OCC_ONE;
      default: occ_nxt = occ;
    endcase
    head_bad = rd_en & (dataout != mem[rd_ptr]);
    cnt_bad  = (count != occ_nxt)
             | (full  != (occ_nxt == DEPTH))
             | (empty != (occ_nxt == '0));
    goal_hit = (state == SEEK_FULL) ? full : empty;
    last     = (step_cnt == LAST);
  end

  assign goal_state   = state;
  assign episode_done = last;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      state         <= SEEK_FULL;
      goal_cnt      <= '0;
      step_cnt      <= '0;
      reward        <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_data      <= 1'b0;
      err_count     <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= datain;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      occ <= occ_nxt;

      if (ovf) err_overflow <= 1'b1;
      if (unf) err_underflow <= 1'b1;
      if (head_bad) err_data <= 1'b1;
      // count checks are meaningless once the shadow has diverged
      if (cnt_bad & ~ovf & ~unf & ~err_overflow & ~err_underflow)
        err_count <= 1'b1;

      reward <= goal_hit;
      if (goal_hit) begin
        goal_cnt <= goal_cnt + STEP_ONE;
        state    <= (state == SEEK_FULL) ? SEEK_EMPTY : SEEK_FULL;
      end

      if (last) begin
        step_cnt <= '0;
        goal_cnt <= '0;
        state    <= SEEK_FULL;
      end else begin
        step_cnt <= step_cnt + STEP_ONE;
      end
    end
  end

endmodule
